// File: rtl/output_argmax.sv
// Consumer end of the output neuron layer: tracks the largest signed score of
// each frame and presents its index and value on a valid/ready result port.
module output_argmax #(
  parameter int num_classes = 10,
  parameter int resolution  = 8,
  parameter int class_width = $clog2(num_classes)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [resolution-1:0]  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [class_width-1:0] out_class,
  output logic [resolution-1:0]  out_score,
  output logic                   frame_error
);

  localparam logic [class_width-1:0] LAST_IDX = class_width'(num_classes - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  state_t                         state_q, state_d;
  logic        [class_width-1:0]  count_q, count_d;
  logic signed [resolution-1:0]   max_q, max_d;
  logic        [class_width-1:0]  idx_q, idx_d;
  logic        [class_width-1:0]  class_q, class_d;
  logic signed [resolution-1:0]   score_q, score_d;
  logic                           ferr_q, ferr_d;

  logic signed [resolution-1:0]   score_in;
  logic signed [resolution-1:0]   cand_max;
  logic        [class_width-1:0]  cand_idx;
  logic                           accept;
  logic                           take_beat;
  logic                           at_last;

  // Strict signed compare: ties keep the earlier (lower) index.
  function automatic logic is_greater(input logic signed [resolution-1:0] a,
                                      input logic signed [resolution-1:0] b);
    return a > b;
  endfunction

  assign score_in  = $signed(in_data);
  assign accept    = in_valid && (state_q == ACCUM);
  assign at_last   = (count_q == LAST_IDX);
  assign take_beat = (count_q == '0) || is_greater(score_in, max_q);
  assign cand_max  = take_beat ? score_in : max_q;
  assign cand_idx  = take_beat ? count_q : idx_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
    idx_d   = idx_q;
    class_d = class_q;
    score_d = score_q;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: state_d = ACCUM;
      ACCUM: begin
        if (accept) begin
          if (at_last && in_last) begin
            max_d   = cand_max;
            idx_d   = cand_idx;
            class_d = cand_idx;
            score_d = cand_max;
            count_d = '0;
            state_d = RESULT;
          end else if (at_last || in_last) begin
            // Misframed: drop the partial frame, keep the previous result.
            ferr_d  = 1'b1;
            count_d = '0;
          end else begin
            max_d   = cand_max;
            idx_d   = cand_idx;
            count_d = count_q + 1'b1;
          end
        end
      end
      RESULT: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      class_q <= '0;
      score_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      class_q <= class_d;
      score_q <= score_d;
      ferr_q  <= ferr_d;
    end
  end

  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == RESULT);
  assign out_class   = class_q;
  assign out_score   = score_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_output_argmax.sv
// Scoreboard bench for output_argmax: frames are driven, expected argmax
// results queued at drive time and compared on each result handshake.
module tb_output_argmax;

  localparam int NC  = 10;
  localparam int RES = 8;
  localparam int CW  = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [RES-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_class;
  logic signed [RES-1:0] out_score;
  logic                  frame_error;

  typedef struct {
    int cls;
    int score;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   fr[NC];
  int   n_tests = 0;
  int   n_fail  = 0;

  output_argmax #(
    .num_classes(NC),
    .resolution (RES),
    .class_width(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_score  (out_score),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic res_t model(input int s[NC]);
    res_t r;
    r.cls   = 0;
    r.score = s[0];
    for (int i = 1; i < NC; i++) begin
      if (s[i] > r.score) begin
        r.score = s[i];
        r.cls   = i;
      end
    end
    return r;
  endfunction

  // Result monitor: a handshake happens on the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_class", int'(out_class), mon_e.cls);
        check("out_score", int'(out_score), mon_e.score);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int d, input logic l);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_data  = d[RES-1:0];
    in_last  = l;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input logic final_last,
                            input int gap_max, input bit good);
    if (good) exp_q.push_back(model(fr));
    for (int i = 0; i < nbeats; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) idle_cycle();
      send_beat(fr[i], (i == nbeats - 1) ? final_last : 1'b0);
    end
    if (good) begin
      @(negedge clk);
      check("latency_out_valid", int'(out_valid), 1);
      check("good_frame_error", int'(frame_error), 0);
    end else begin
      @(negedge clk);
      check("ferr_pulse", int'(frame_error), 1);
      check("ferr_no_valid", int'(out_valid), 0);
      @(negedge clk);
      check("ferr_one_cycle", int'(frame_error), 0);
      check("ferr_no_valid2", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_class", int'(out_class), 0);
    check("rst_out_score", int'(out_score), 0);
    check("rst_frame_error", int'(frame_error), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;

    // Basic frame with a tie on the maximum
    fr = '{3, -5, 7, 1, 0, -128, 7, 2, 6, 4};
    out_ready = 1'b1;
    send_frame(NC, 1'b1, 0, 1'b1);
    @(negedge clk);
    check("bubble_in_ready", int'(in_ready), 1);
    check("after_hs_valid", int'(out_valid), 0);
    check("held_class", int'(out_class), 2);
    check("held_score", int'(out_score), 7);
    @(posedge clk);
    #1;

    // All minimum, then max on the final beat
    for (int i = 0; i < NC; i++) fr[i] = -128;
    send_frame(NC, 1'b1, 0, 1'b1);
    for (int i = 0; i < NC; i++) fr[i] = 0;
    fr[NC-1] = 127;
    send_frame(NC, 1'b1, 0, 1'b1);

    // Result held under back-pressure while inputs are offered
    fr = '{12, -40, 33, 90, -7, 90, 5, 0, -1, 64};
    out_ready = 1'b0;
    send_frame(NC, 1'b1, 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'sd100;
      in_last  = 1'b1;
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_class", int'(out_class), 3);
      check("hold_score", int'(out_score), 90);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hold_release_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Early in_last, then a good frame
    fr = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_frame(5, 1'b1, 0, 1'b0);
    check("ferr_keeps_class", int'(out_class), 3);
    fr = '{-3, 10, 20, -50, 49, 0, 50, 50, -128, 1};
    send_frame(NC, 1'b1, 0, 1'b1);

    // Missing in_last on the final beat
    fr = '{100, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    send_frame(NC, 1'b0, 0, 1'b0);
    check("ferr2_keeps_score", int'(out_score), 50);

    // Same frame with and without in_valid gaps
    fr = '{5, -2, 40, 99, 99, -99, 0, 98, 7, -128};
    send_frame(NC, 1'b1, 3, 1'b1);
    send_frame(NC, 1'b1, 0, 1'b1);

    // Async reset mid-frame
    fr = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 6; i++) send_beat(fr[i], 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_in_ready", int'(in_ready), 0);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_class", int'(out_class), 0);
    check("arst_out_score", int'(out_score), 0);
    check("arst_frame_error", int'(frame_error), 0);
    @(negedge clk);
    check("arst_hold_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("arst_rel_idle", int'(in_ready), 0);
    @(negedge clk);
    check("arst_rel_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    fr = '{-10, -20, -5, -30, -6, -7, -8, 60, -1, 59};
    send_frame(NC, 1'b1, 0, 1'b1);

    // Async reset with a pending result
    out_ready = 1'b0;
    fr = '{0, 1, 2, 3, 4, 88, 6, 7, 8, 9};
    send_frame(NC, 1'b1, 0, 1'b1);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("arst2_out_valid", int'(out_valid), 0);
    check("arst2_out_class", int'(out_class), 0);
    check("arst2_out_score", int'(out_score), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arst2_rel_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    fr = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, 0};
    send_frame(NC, 1'b1, 0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
